// File: rtl/psum_requant_pkg.sv
// psum_pkg: FSM state encoding, datapath width and 8-bit clip bounds that
// psum_requant and requant_clip share.
package psum_pkg;
  localparam int ACC_W = 32;
  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

  typedef enum logic [1:0] {IDLE, ACC, LAST, FLUSH} state_t;
endpackage

// File: rtl/psum_requant_if.sv
// psum_requant_if: partial-sum input stream and quantized-pixel output stream,
// each with a valid/ready handshake.
interface psum_requant_if;
  import psum_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/psum_requant_clip.sv
// requant_clip: combinational bias add, round-half-up arithmetic shift and 8-bit clip.
// Build option: define PSUM_RELU_EN to clip to [0,127] instead of [-128,127].
module requant_clip
  import psum_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_val,
  input  logic signed [ACC_W-1:0] psum,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [4:0]       shift,
  output logic        [7:0]       q
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(Q_MAX);
`ifdef PSUM_RELU_EN
  localparam logic signed [ACC_W-1:0] LO = '0;
`else
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(Q_MIN);
`endif

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    sum = acc_val + psum + bias;
    // Rounding constant is zero for shift 0, so one expression covers both cases.
    rnd = '0;
    if (shift != 5'd0) rnd = ACC_W'(1) << (shift - 5'd1);
    shifted = (sum + rnd) >>> shift;
    if (shifted > HI)      q = HI[7:0];
    else if (shifted < LO) q = LO[7:0];
    else                   q = shifted[7:0];
  end
endmodule

// File: rtl/psum_requant.sv
// psum_requant: accumulates a row of partial sums across input channels, then
// requantizes each pixel to 8 bits on the final pass. PSUM_RELU_EN selects ReLU clip.
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accumulating channels 0..ch_num-2, one partial sum per cycle
// LAST  | final channel: add bias, requantize, emit each pixel
// FLUSH | last pixel accepted, waiting for the final output handshake
module psum_requant
  import psum_pkg::*;
#(
  parameter int ROW_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       ch_num,
  input  logic [5:0]       row_len,
  input  logic [4:0]       shift,
  input  logic [ACC_W-1:0] bias,
  psum_requant_if.slave    bus,
  output logic             busy,
  output logic             done
);
  localparam int PIX_W = $clog2(ROW_LEN);

  state_t state, state_nx;

  logic [PIX_W-1:0]        pix;
  logic [7:0]              ch_cnt;
  logic [7:0]              ch_num_q;
  logic [5:0]              row_len_q;
  logic [4:0]              shift_q;
  logic signed [ACC_W-1:0] bias_q;
  logic                    out_valid_q;
  logic [7:0]              out_data_q;
  logic                    in_rdy;

  logic signed [ACC_W-1:0] acc [ROW_LEN];
  logic signed [ACC_W-1:0] in_data;
  logic signed [ACC_W-1:0] acc_term;
  logic [7:0]              q;
  logic                    in_hs;
  logic                    out_hs;
  logic                    pix_last;

  assign in_data       = bus.in_data;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);

  assign in_hs    = bus.in_valid && in_rdy;
  assign out_hs   = out_valid_q && bus.out_ready;
  assign pix_last = (6'(pix) == row_len_q - 6'd1);
  // A single-channel job has no earlier passes, so the stale accumulator is ignored.
  assign acc_term = (ch_num_q == 8'd1) ? '0 : acc[pix];

  requant_clip u_clip (
    .acc_val (acc_term),
    .psum    (in_data),
    .bias    (bias_q),
    .shift   (shift_q),
    .q       (q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (ch_num <= 8'd1) ? LAST : ACC;
      end
      ACC: begin
        in_rdy = 1'b1;
        if (in_hs && pix_last && (ch_cnt == ch_num_q - 8'd2)) state_nx = LAST;
      end
      LAST: begin
        in_rdy = !out_valid_q || bus.out_ready;
        if (in_hs && pix_last) state_nx = FLUSH;
      end
      FLUSH: begin
        if (out_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix         <= '0;
      ch_cnt      <= '0;
      ch_num_q    <= 8'd1;
      row_len_q   <= 6'(ROW_LEN);
      shift_q     <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == FLUSH) && out_hs;
      if (state == IDLE && start) begin
        ch_num_q  <= (ch_num == 8'd0) ? 8'd1 : ch_num;
        row_len_q <= (row_len == 6'd0) ? 6'(ROW_LEN) : row_len;
        shift_q   <= shift;
        bias_q    <= bias;
        pix       <= '0;
        ch_cnt    <= '0;
      end else if (in_hs) begin
        if (pix_last) begin
          pix    <= '0;
          ch_cnt <= ch_cnt + 8'd1;
        end else begin
          pix <= pix + PIX_W'(1);
        end
      end
      if (state == LAST && in_hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= q;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Accumulator has no reset: channel 0 of every job overwrites each entry.
  always_ff @(posedge clk) begin
    if (!rst && state == ACC && in_hs)
      acc[pix] <= (ch_cnt == 8'd0) ? in_data : acc[pix] + in_data;
  end
endmodule

// File: tb/tb_psum_requant.sv
// tb_psum_requant: directed table of single-pixel requant vectors plus hand-built
// multi-cycle jobs (multi-channel, backpressure, start-while-busy, reset, row_len 0).
module tb_psum_requant;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ch_num = 8'd1;
  logic [5:0]  row_len = 6'd1;
  logic [4:0]  shift = 5'd0;
  logic [31:0] bias = 32'd0;
  logic        busy;
  logic        done;

  psum_requant_if bus();

  psum_requant dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ch_num  (ch_num),
    .row_len (row_len),
    .shift   (shift),
    .bias    (bias),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [7:0]  es;  // signed clip result
    logic [7:0]  er;  // ReLU clip result
  } vec_t;

  vec_t        vt[15];
  logic [31:0] din_q[$];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [7:0] pick(input logic [7:0] s, input logic [7:0] r);
`ifdef PSUM_RELU_EN
    return r;
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Runs one job from din_q, comparing outputs against exp_q. out_ready is low for
  // cycles [stall_at, stall_at+stall_len); mid_start >= 0 pulses a bogus start then.
  task automatic run_job(input string name, input logic [7:0] ch, input logic [5:0] rl,
                         input logic [4:0] sh, input logic [31:0] b,
                         input int stall_at, input int stall_len, input int mid_start);
    int         idx = 0;
    int         k = 0;
    int         done_cyc = -1;
    int         last_out_cyc = -2;
    logic       was_stalled = 1'b0;
    logic [7:0] held = '0;
    @(posedge clk); #1;
    ch_num = ch; row_len = rl; shift = sh; bias = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s busy_after_start", name), 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
      bus.in_valid  = (idx < din_q.size());
      bus.in_data   = (idx < din_q.size()) ? din_q[idx] : 32'd0;
      bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == mid_start) begin
        start = 1'b1; ch_num = 8'd1; row_len = 6'd1; shift = 5'd7; bias = 32'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        check($sformatf("%s busy_at_done", name), 32'(busy), 32'd0);
      end
      if (bus.out_valid && !bus.out_ready) begin
        check($sformatf("%s in_ready_stalled", name), 32'(bus.in_ready), 32'd0);
        if (was_stalled) check($sformatf("%s held_data", name), 32'(bus.out_data), 32'(held));
        held = bus.out_data;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        if (k < exp_q.size())
          check($sformatf("%s out[%0d]", name, k), 32'(bus.out_data), 32'(exp_q[k]));
        k++;
        last_out_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check($sformatf("%s inputs_accepted", name), 32'(idx), 32'(din_q.size()));
    check($sformatf("%s outputs", name), 32'(k), 32'(exp_q.size()));
    check($sformatf("%s done_timing", name), 32'(done_cyc), 32'(last_out_cyc + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'hFFFFFFFA, 32'd0,        5'd2,  8'hFF, 8'h00};
    vt[1]  = '{32'd100,      32'd27,       5'd0,  8'h7F, 8'h7F};
    vt[2]  = '{32'd100,      32'd28,       5'd0,  8'h7F, 8'h7F};
    vt[3]  = '{32'hFFFFFF38, 32'd0,        5'd0,  8'h80, 8'h00};
    vt[4]  = '{32'hFFFFFF80, 32'd0,        5'd0,  8'h80, 8'h00};
    vt[5]  = '{32'hFFFFFF7F, 32'd0,        5'd0,  8'h80, 8'h00};
    vt[6]  = '{32'd5,        32'd1,        5'd1,  8'h03, 8'h03};
    vt[7]  = '{32'd7,        32'd0,        5'd1,  8'h04, 8'h04};
    vt[8]  = '{32'hFFFFFFFB, 32'd0,        5'd1,  8'hFE, 8'h00};
    vt[9]  = '{32'h7FFFFFFF, 32'd1,        5'd0,  8'h80, 8'h00};
    vt[10] = '{32'd1000,     32'd24,       5'd3,  8'h7F, 8'h7F};
    vt[11] = '{32'd1000,     32'd0,        5'd31, 8'h00, 8'h00};
    vt[12] = '{32'h40000000, 32'h40000000, 5'd31, 8'hFF, 8'h00};
    vt[13] = '{32'hFFFFFC18, 32'hFFFFFFE8, 5'd3,  8'h80, 8'h00};
    vt[14] = '{32'd10,       32'hFFFFFFFD, 5'd0,  8'h07, 8'h07};

    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);

    for (int i = 0; i < 15; i++) begin
      din_q = {vt[i].din};
      exp_q = {pick(vt[i].es, vt[i].er)};
      run_job($sformatf("vec%0d", i), 8'd1, 6'd1, vt[i].sh, vt[i].b, -1, 0, -1);
    end

    din_q = {32'd5, 32'hFFFFFFFD, 32'd200, 32'd127};
    exp_q = {8'd5, pick(8'hFD, 8'h00), 8'h7F, 8'h7F};
    run_job("passthru", 8'd1, 6'd4, 5'd0, 32'd0, -1, 0, -1);

    din_q = {32'd10, 32'd20, 32'd1, 32'd2, 32'd100, 32'd200};
    exp_q = {8'd29, 8'd57};
    run_job("three_ch", 8'd3, 6'd2, 5'd2, 32'd4, -1, 0, -1);

    // ch_num 0 behaves as a single channel
    din_q = {32'd1, 32'd2, 32'd3, 32'd4};
    exp_q = {8'd1, 8'd2, 8'd3, 8'd4};
    run_job("backpressure", 8'd0, 6'd4, 5'd0, 32'd0, 2, 3, -1);

    din_q = {32'd1, 32'd2, 32'd3, 32'd4};
    exp_q = {8'd4, 8'd6};
    run_job("start_busy", 8'd2, 6'd2, 5'd0, 32'd0, -1, 0, 1);

    // Reset during LAST with an output pending
    @(posedge clk); #1;
    ch_num = 8'd1; row_len = 6'd4; shift = 5'd0; bias = 32'd0; start = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_job out_valid_latency", 32'(bus.out_valid), 32'd1);
    check("rst_job out_data", 32'(bus.out_data), 32'd9);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_job out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_job busy", 32'(busy), 32'd0);
    check("rst_job in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_job out_data", 32'(bus.out_data), 32'd0);
    check("rst_job done", 32'(done), 32'd0);

    din_q = {32'd7, 32'd8, 32'd1, 32'd1};
    exp_q = {8'd8, 8'd9};
    run_job("after_rst", 8'd2, 6'd2, 5'd0, 32'd0, -1, 0, -1);

    // row_len 0 means 32 pixels; channel 1 adds 2*i, so each sum is 3*i - 40
    din_q.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(32'(i));
    for (int i = 0; i < 32; i++) din_q.push_back(32'(2 * i));
    for (int i = 0; i < 32; i++) begin
      int v;
      v = 3 * i - 40;
      exp_q.push_back(pick(8'(v), (v < 0) ? 8'd0 : 8'(v)));
    end
    run_job("row_len0", 8'd2, 6'd0, 5'd0, 32'hFFFFFFD8, -1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/psum_requant.md
# psum_requant

Downstream stage of the 25-tap convolution array. It takes the 32-bit signed partial sums the array emits, one per output pixel of a row, and accumulates them across input channels in a row-wide accumulator. On the final channel pass it adds a per-filter bias, applies a rounding arithmetic shift and clips the result to 8 bits. It then streams the quantized pixels out over a valid/ready handshake.

## Interface
- `ROW_LEN`, 32: maximum output pixels per row, which is also the accumulator depth.
- `ACC_W`, 32: accumulator and partial-sum width in bits.
- `clk` in 1: single clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches the configuration and begins a row job. Ignored while `busy`=1.
- `ch_num` in 8: number of input channels to accumulate. 0 is treated as 1.
- `row_len` in 6: pixels per row, 1..`ROW_LEN`. 0 is treated as `ROW_LEN`.
- `shift` in 5: requantization right-shift amount, 0..31.
- `bias` in 32: signed bias, added once per pixel on the last pass.
- `in_valid` in 1: partial sum is present on `in_data`.
- `in_ready` out 1: the block can accept a partial sum this cycle.
- `in_data` in 32: signed partial sum. Order is pixel-major within a channel and channel-major overall.
- `out_valid` out 1: `out_data` holds a quantized pixel.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_data` out 8: quantized pixel.
- `busy` out 1: a job is in progress.
- `done` out 1: one-cycle pulse after the final output handshake of a job.

## Operation
- States and transitions:
  - IDLE goes to ACC on `start`.
  - ACC goes to LAST when the pixel counter wraps with `ch_cnt == ch_num-2`.
  - IDLE goes directly to LAST on `start` when `ch_num` ≤ 1.
  - LAST goes to FLUSH after the last pixel is accepted.
  - FLUSH goes to IDLE after the final output handshake; `done`=1 in that cycle.
- Counters:
  - `pix` runs 0..`row_len`-1 and wraps to 0.
  - `ch_cnt` increments on each `pix` wrap.
  - Both advance only on an input handshake.
- ACC state, with `in_ready`=1:
  - Channel 0: acc[pix] = `in_data`.
  - Later channels: acc[pix] = acc[pix] + `in_data`.
- LAST state, value formed on an accepted pixel:
  - s = acc[pix] + `in_data` + `bias`. If `ch_num`=1, acc[pix] is replaced by 0.
  - If `shift` > 0, r = (s + (1 << (`shift`-1))) >>> `shift`; otherwise r = s.
  - r is clipped to 8 bits (see Configuration) and loaded into `out_data`.
- LAST state, backpressure: `in_ready` = !`out_valid` || `out_ready`.
- All additions are `ACC_W` bits and wrap in two's complement. There is no saturation before the shift.
- The accumulator is a register array with combinational read and is not cleared between jobs; channel 0 overwrites it.
- `ch_num`, `row_len`, `shift` and `bias` are latched on `start`; later changes to the inputs are ignored.

## Timing
- Reset values:
  - State IDLE; `pix` = `ch_cnt` = 0.
  - `in_ready` = `out_valid` = `busy` = `done` = 0; `out_data` = 0.
  - Accumulator contents after reset are don't-care.
- `busy` goes to 1 the cycle after `start`. `in_ready` can first be 1 in that same cycle.
- In ACC, one partial sum is accepted per cycle with no stalls.
- Output latency: `out_valid` rises 1 cycle after the LAST-pass input handshake.
- `out_valid` and `out_data` are held stable until `out_ready`=1.
- A simultaneous output handshake and new input acceptance in the same cycle is allowed, giving full throughput.
- `done` pulses in the cycle after the final output handshake. `busy` falls in that same cycle.
- `rst` asserted mid-job aborts the job and returns all outputs to their reset values on the next edge. Any pending `out_data` is discarded.

## Configuration
- `PSUM_RELU_EN` defined: r is clipped to [0, 127], so negatives become 0.
- `PSUM_RELU_EN` undefined: r is clipped to signed [-128, 127].

## Structure
- Shared package `psum_pkg`:
  - State encoding: IDLE, ACC, LAST, FLUSH.
  - `ACC_W`.
  - Clip bounds `Q_MAX`=127, `Q_MIN`=-128.
- One sub-module `requant_clip`: combinational add-bias, round, shift and clip from 32 bits to 8 bits. It contains the `PSUM_RELU_EN` switch.

## Test plan
- **Single-channel passthrough:** `ch_num`=1, `row_len`=4, `shift`=0, `bias`=0, `in_data` = 5, -3, 200, 127, `out_ready`=1.
  - Without the macro: `out_data` = 5, -3, 127, 127; `done` 1 cycle after the 4th output.
  - With the macro: -3 becomes 0.
- **Three-channel accumulate:** `ch_num`=3, `row_len`=2, `in_data` = 10, 20, 1, 2, 100, 200, `bias`=4, `shift`=2.
  - Sums are 115 and 226; outputs are (115+2)>>2 = 29 and (226+2)>>2 = 57, clipped to 57.
- **Backpressure:** `out_ready` low for 3 cycles on the LAST pass.
  - `in_ready`=0 while stalled; `out_data` stays stable; no data lost or duplicated.
- **Negative rounding:** `ch_num`=1, `in_data`=-6, `shift`=2.
  - (-6+2)>>>2 = -1, giving -1 without the macro and 0 with it.
- **Start while busy, then reset mid-job:**
  - A `start` pulse during ACC has no effect.
  - Asserting `rst` during LAST gives `out_valid`=0, `busy`=0 next cycle.
  - A new job afterwards produces correct results, because channel 0 overwrites the accumulator.
- **Boundary `row_len`=0** (treated as 32) with `ch_num`=2: exactly 64 inputs accepted and 32 outputs produced, and `pix` wraps correctly.
